// File: rtl/multiword_addsub_seq.sv
// Purpose : W-bit add/subtract (W = N*WORDS) computed on one shared N-bit adder slice, LSB slice first.
// Latency : done pulses in the cycle after edge t0+WORDS (t0 = start edge); start-to-start >= WORDS+2 cycles.
// Backpressure: none; start is sampled only in IDLE, ignored while busy, never queued.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start, op_sub   request and operation select (0 = A+B, 1 = A-B), captured with start
//   a, b            W-bit operands, captured with start
//   busy, done      busy in RUN/DONE; done is a one-cycle completion pulse
//   result, cout, v W-bit result, final carry (no-borrow for subtract), signed overflow
module multiword_addsub_seq #(
    parameter int N     = 4,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_sub,
    input  logic [N*WORDS-1:0] a,
    input  logic [N*WORDS-1:0] b,
    output logic               busy,
    output logic               done,
    output logic [N*WORDS-1:0] result,
    output logic               cout,
    output logic               v
);

    localparam int W  = N * WORDS;
    localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Operands shift right by one slice per RUN cycle, so the active slice
    // always sits in the low N bits. B is pre-inverted for subtraction.
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic          carry;
    logic [CW-1:0] cnt;

    logic [N:0]    slice;
    logic          last;

    // The shared slice adder: carry-in only ever comes from the carry register.
    assign slice = {1'b0, a_sh[N-1:0]} + {1'b0, b_sh[N-1:0]} + {{N{1'b0}}, carry};
    assign last  = (cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN: begin
                busy = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            v      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= op_sub ? ~b : b;
                        // Carry-in of 1 completes the two's-complement negation of B.
                        carry <= op_sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    result[int'(cnt)*N +: N] <= slice[N-1:0];
                    carry <= slice[N];
                    a_sh  <= {{N{1'b0}}, a_sh[W-1:N]};
                    b_sh  <= {{N{1'b0}}, b_sh[W-1:N]};
                    if (last) begin
                        // Top slice: its MSBs are the sign bits of the full-width operation.
                        cout <= slice[N];
                        v    <= (a_sh[N-1] == b_sh[N-1]) && (slice[N-1] != a_sh[N-1]);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_addsub_seq.sv
module tb_multiword_addsub_seq;

    localparam int N     = 4;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         v;

    int total;
    int bad;

    multiword_addsub_seq #(.N(N), .WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .v      (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] va;
        logic [15:0] vb;
        logic        vsub;
        logic [15:0] er;
        logic        ec;
        logic        ev;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Runs one operation from IDLE; returns outputs seen with done, the
    // number of edges from t0 to done, busy-high samples and whether done
    // was still high one cycle later.
    logic [15:0] r_res;
    logic        r_cout;
    logic        r_v;
    int          r_lat;
    int          r_busy;
    logic        r_done_after;

    task automatic do_op(input logic [15:0] ia, input logic [15:0] ib, input logic isub);
        @(negedge clk);
        a      = ia;
        b      = ib;
        op_sub = isub;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = ~ia;
        b      = ~ib;
        op_sub = ~isub;
        r_lat  = 0;
        r_busy = busy ? 1 : 0;
        while (!done && r_lat < 20) begin
            @(posedge clk);
            #1;
            r_lat++;
            if (busy) r_busy++;
        end
        r_res  = result;
        r_cout = cout;
        r_v    = v;
        @(posedge clk);
        #1;
        r_done_after = done;
        if (busy) r_busy++;
    endtask

    initial begin
        int ndone;
        int last_cyc;
        logic [15:0] b2b_a[3];
        logic [15:0] b2b_b[3];
        logic [15:0] b2b_e[3];

        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        a      = 16'h0;
        b      = 16'h0;

        vecs[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   busy,   0);
        check("reset_done",   done,   0);
        check("reset_result", result, 0);
        check("reset_cout",   cout,   0);
        check("reset_v",      v,      0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven operations
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].va, vecs[i].vb, vecs[i].vsub);
            check($sformatf("vec%0d_latency", i),   r_lat,        4);
            check($sformatf("vec%0d_result", i),    r_res,        vecs[i].er);
            check($sformatf("vec%0d_cout", i),      r_cout,       vecs[i].ec);
            check($sformatf("vec%0d_v", i),         r_v,          vecs[i].ev);
            check($sformatf("vec%0d_busy_cyc", i),  r_busy,       5);
            check($sformatf("vec%0d_done_pulse", i), r_done_after, 0);
            // Outputs hold in IDLE
            check($sformatf("vec%0d_hold", i),      result,       vecs[i].er);
        end

        // Restart pulses and operand changes while busy are ignored
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = 16'hAAAA; b = 16'h5555; op_sub = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ndone++;
                check("ignore_start_result", result, 16'h3333);
                check("ignore_start_cout",   cout,   0);
            end
            if (k == 1 || k == 4) begin
                start = 1'b1; a = 16'h0F0F; b = 16'h7070; op_sub = 1'b1;
            end else begin
                start = 1'b0; a = 16'hC3C3; b = 16'h3C3C;
            end
        end
        check("ignore_start_ndone", ndone, 1);
        check("ignore_start_final", result, 16'h3333);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 16'h1234; b = 16'h0FFF; op_sub = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_busy",   busy,   0);
        check("midrst_done",   done,   0);
        check("midrst_result", result, 0);
        check("midrst_cout",   cout,   0);
        check("midrst_v",      v,      0);
        ndone = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        do_op(16'h0001, 16'h0001, 1'b0);
        check("after_rst_latency", r_lat, 4);
        check("after_rst_result",  r_res, 16'h0002);

        // Back-to-back with start held high
        b2b_a[0] = 16'h0102; b2b_b[0] = 16'h0304; b2b_e[0] = 16'h0406;
        b2b_a[1] = 16'hF00F; b2b_b[1] = 16'h0FF1; b2b_e[1] = 16'h0000;
        b2b_a[2] = 16'h4321; b2b_b[2] = 16'h1111; b2b_e[2] = 16'h5432;
        @(negedge clk);
        a = b2b_a[0]; b = b2b_b[0]; op_sub = 1'b0; start = 1'b1;
        ndone    = 0;
        last_cyc = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                check($sformatf("b2b%0d_result", ndone), result, b2b_e[ndone]);
                if (ndone > 0) check($sformatf("b2b%0d_spacing", ndone), cyc - last_cyc, 6);
                last_cyc = cyc;
                ndone++;
                if (ndone < 3) begin
                    a = b2b_a[ndone]; b = b2b_b[ndone];
                end else begin
                    start = 1'b0;
                end
            end else if (last_cyc >= 0 && cyc == last_cyc + 1) begin
                check($sformatf("b2b%0d_hold", ndone - 1), result, b2b_e[ndone - 1]);
            end
            if (ndone == 3 && cyc > last_cyc + 1) break;
        end
        start = 1'b0;
        check("b2b_ndone", ndone, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
